// File: rtl/rv_pkg.sv
// Shared fetch-path types and constants: word width, canonical NOP, default
// reset PC and the {pc, inst} entry carried from fetch to decode.
package rv_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0100_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: DEPTH x fetch_entry_t ring with separate count, so full
// and empty are unambiguous; flush empties it in one cycle.
module fetch_fifo import rv_pkg::*; #(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  output fetch_entry_t head,
  output logic [CW-1:0] count,
  output logic         full,
  output logic         empty
);
  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    mem_d   = mem_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    if (flush) begin
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_q] = push_entry;
        wr_d        = wr_q + 1'b1;
      end
      if (pop) rd_d = rd_q + 1'b1;
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // Storage is cleared on reset too, so nothing from before reset can resurface.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end

  assign head  = mem_q[rd_q];
  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC generation, credit-limited imem issue, response buffering.
// Optional FETCH_STATS_EN adds stat_fetched/stat_killed counters.
module fetch_unit import rv_pkg::*; #(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int              DEPTH    = 2
) (
  input  logic            clock,
  input  logic            reset,
  output logic [XLEN-1:0] imem_addr,
  output logic            imem_req,
  input  logic [XLEN-1:0] imem_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]     stat_fetched,
  output logic [31:0]     stat_killed
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] pc_q, pc_d, tag_q, tag_d;
  logic            inflight_q, inflight_d;
  fetch_entry_t    ret_entry, head;
  logic [CW-1:0]   count;
  logic            full, empty;
  logic            ret_valid, handshake, fifo_push, fifo_pop;
  logic [CW:0]     occupancy;

  always_comb begin
    occupancy = {1'b0, count} + {{CW{1'b0}}, inflight_q};
    imem_req  = reset && (occupancy < (CW+1)'(DEPTH)) && !redirect_valid;
    imem_addr = pc_q;
    // A response returning in a redirect cycle is killed here by never pushing it.
    ret_valid = inflight_q && !redirect_valid;
    ret_entry = '{pc: tag_q, inst: imem_data};
    inst_valid = !empty || ret_valid;
    handshake  = inst_valid && inst_ready;
    fifo_pop   = handshake && !empty;
    fifo_push  = ret_valid && !(empty && handshake);
    inst_pc = '0;
    inst    = '0;
    if (!empty) begin
      inst_pc = head.pc;
      inst    = head.inst;
    end else if (ret_valid) begin
      inst_pc = ret_entry.pc;
      inst    = ret_entry.inst;
    end
    pc_d       = pc_q;
    tag_d      = tag_q;
    inflight_d = imem_req;
    if (redirect_valid) begin
      pc_d = {redirect_pc[XLEN-1:2], 2'b00};
    end else if (imem_req) begin
      pc_d  = pc_q + 32'd4;
      tag_d = pc_q;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      pc_q       <= RESET_PC;
      tag_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .flush      (redirect_valid),
    .push       (fifo_push),
    .push_entry (ret_entry),
    .pop        (fifo_pop),
    .head       (head),
    .count      (count),
    .full       (full),
    .empty      (empty)
  );

  a_no_overflow: assert property (@(posedge clock) disable iff (!reset)
    !(fifo_push && full && !fifo_pop && !redirect_valid))
    else $error("fetch buffer overflow");

`ifdef FETCH_STATS_EN
  logic [31:0] fetched_q, fetched_d, killed_q, killed_d;

  always_comb begin
    fetched_d = fetched_q + 32'(ret_valid);
    killed_d  = killed_q;
    // A head popped in the redirect cycle was consumed, not flushed.
    if (redirect_valid)
      killed_d = killed_q + 32'(inflight_q) + 32'(count) - 32'(fifo_pop);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      fetched_q <= '0;
      killed_q  <= '0;
    end else begin
      fetched_q <= fetched_d;
      killed_q  <= killed_d;
    end
  end

  assign stat_fetched = fetched_q;
  assign stat_killed  = killed_q;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, stall, redirects, PC wrap, reset
// mid-stall. Memory returns its address as data one cycle after the request.
module tb_fetch_unit;
  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] imem_addr, imem_data, redirect_pc, inst, inst_pc;
  logic        imem_req, redirect_valid, inst_valid, inst_ready;
`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched, stat_killed;
`endif

  int checks   = 0;
  int failures = 0;

  fetch_unit dut (
    .clock          (clock),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_req       (imem_req),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc)
`ifdef FETCH_STATS_EN
    ,
    .stat_fetched   (stat_fetched),
    .stat_killed    (stat_killed)
`endif
  );

  always #5 clock = ~clock;

  always @(posedge clock) imem_data <= imem_addr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic advance();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_inst(input string tag, input logic [31:0] pc);
    check({tag, "_valid"}, {31'b0, inst_valid}, 32'd1);
    check({tag, "_pc"}, inst_pc, pc);
    check({tag, "_inst"}, inst, pc);
  endtask

  logic [31:0] exp_pc;

  initial begin
    reset          = 1'b0;
    inst_ready     = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    advance();
    advance();
    @(negedge clock);
    check("rst_valid", {31'b0, inst_valid}, 32'd0);
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_inst_pc", inst_pc, 32'd0);
    advance();
    reset = 1'b1;

    // cycle 0: first fetch, nothing returned yet
    @(negedge clock);
    check("c0_req", {31'b0, imem_req}, 32'd1);
    check("c0_addr", imem_addr, 32'h0100_0000);
    check("c0_valid", {31'b0, inst_valid}, 32'd0);
    advance();

    // cycles 1..6: one instruction per cycle
    exp_pc = 32'h0100_0000;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock);
      expect_inst("stream", exp_pc);
      check("stream_addr", imem_addr, exp_pc + 32'd4);
      exp_pc = exp_pc + 32'd4;
      advance();
    end

    // cycles 7..11: stall; head 0x...18 held, issue stops once two are outstanding
    inst_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      expect_inst("stall", 32'h0100_0018);
      check("stall_req", {31'b0, imem_req}, (k == 0) ? 32'd1 : 32'd0);
      advance();
    end

    // cycles 12..15: drain in order, issue resumes the cycle after the first pop
    inst_ready = 1'b1;
    @(negedge clock);
    expect_inst("drain0", 32'h0100_0018);
    check("drain0_req", {31'b0, imem_req}, 32'd0);
    advance();
    @(negedge clock);
    expect_inst("drain1", 32'h0100_001C);
    check("drain1_req", {31'b0, imem_req}, 32'd1);
    check("drain1_addr", imem_addr, 32'h0100_0020);
    advance();
    @(negedge clock);
    expect_inst("drain2", 32'h0100_0020);
    advance();
    @(negedge clock);
    expect_inst("drain3", 32'h0100_0024);
    check("drain3_addr", imem_addr, 32'h0100_0028);
    advance();

    // cycles 16..17: one buffered + one inflight, then redirect
    inst_ready = 1'b0;
    advance();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0100_0040;
    @(negedge clock);
    check("redir_req", {31'b0, imem_req}, 32'd0);
    expect_inst("redir_head", 32'h0100_0028);
    advance();
    redirect_valid = 1'b0;
    inst_ready     = 1'b1;
    @(negedge clock);
    check("redir_flush_valid", {31'b0, inst_valid}, 32'd0);
    check("redir_addr", imem_addr, 32'h0100_0040);
    check("redir_req2", {31'b0, imem_req}, 32'd1);
    advance();
    @(negedge clock);
    expect_inst("redir_tgt", 32'h0100_0040);
    advance();
    @(negedge clock);
    expect_inst("redir_next", 32'h0100_0044);
    advance();

    // unaligned target is masked
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0100_0083;
    @(negedge clock);
    check("mask_valid", {31'b0, inst_valid}, 32'd0);
    advance();
    redirect_valid = 1'b0;
    @(negedge clock);
    check("mask_addr", imem_addr, 32'h0100_0080);
    advance();
    @(negedge clock);
    expect_inst("mask_tgt", 32'h0100_0080);
    advance();

    // back-to-back redirects: only the last stream appears
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    advance();
    redirect_pc    = 32'h0000_0300;
    @(negedge clock);
    check("b2b_valid", {31'b0, inst_valid}, 32'd0);
    advance();
    redirect_valid = 1'b0;
    @(negedge clock);
    check("b2b_addr", imem_addr, 32'h0000_0300);
    check("b2b_valid2", {31'b0, inst_valid}, 32'd0);
    advance();
    @(negedge clock);
    expect_inst("b2b_tgt", 32'h0000_0300);
    advance();
    @(negedge clock);
    expect_inst("b2b_next", 32'h0000_0304);
    advance();

    // fill the buffer under stall, then reset
    inst_ready = 1'b0;
    advance();
    advance();
    @(negedge clock);
    expect_inst("full_head", 32'h0000_0308);
    check("full_req", {31'b0, imem_req}, 32'd0);
    advance();
    reset      = 1'b0;
    inst_ready = 1'b1;
    advance();
    reset = 1'b1;
    @(negedge clock);
    check("rst2_valid", {31'b0, inst_valid}, 32'd0);
    check("rst2_addr", imem_addr, 32'h0100_0000);
    check("rst2_req", {31'b0, imem_req}, 32'd1);
`ifdef FETCH_STATS_EN
    check("rst2_fetched", stat_fetched, 32'd0);
    check("rst2_killed", stat_killed, 32'd0);
`endif
    advance();
    @(negedge clock);
    expect_inst("rst2_first", 32'h0100_0000);
    advance();

    // PC wrap at the top of the address space
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    advance();
    redirect_valid = 1'b0;
    @(negedge clock);
    check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    advance();
    @(negedge clock);
    expect_inst("wrap_top", 32'hFFFF_FFFC);
    check("wrap_addr0", imem_addr, 32'h0000_0000);
    advance();
    @(negedge clock);
    expect_inst("wrap_zero", 32'h0000_0000);
    advance();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
